// File: rtl/library_point_extract.sv
// -----------------------------------------------------------------------------
// library_point_extract
//
// Raster point extractor feeding the library store stage. Scans one 32x32
// frame of 8-bit pixels (row-major, x fastest) and reports the (x,y) of every
// pixel at or above THRESH. The outputs follow the start/valid/deny protocol
// that the store consumes. Each frame ends with a single commit cycle, where
// deny is low, so that the store closes the entry.
//
// The block also mirrors the store's entry slot pointer (0..LIB_DEPTH-1,
// wrapping). It counts committed entries so that a new frame is refused once
// the library is full.
//
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_rst          synchronous active-high reset
//   i_frame_start  request a new frame scan (honoured only when idle)
//   i_pix_valid    i_pix carries the next raster pixel
//   i_pix          pixel intensity
//   i_lib_clear    clears the committed-entry count and the full flag
//   o_start        one-cycle pulse that starts the store
//   o_valid        o_x/o_y hold a point
//   o_x, o_y       point coordinates (0 when o_valid is low)
//   o_deny         high keeps the entry open; low only in the commit cycle
//   o_busy         a frame is in progress
//   o_entry_idx    slot that the current/next frame is written to
//   o_lib_full     LIB_DEPTH entries committed since reset/clear
//   o_reject       one-cycle pulse: a frame start was refused (library full)
// -----------------------------------------------------------------------------
module library_point_extract #(
  parameter logic [7:0] THRESH    = 8'd128,
  parameter int         LIB_DEPTH = 26
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_start,
  input  logic       i_pix_valid,
  input  logic [7:0] i_pix,
  input  logic       i_lib_clear,
  output logic       o_start,
  output logic       o_valid,
  output logic [4:0] o_x,
  output logic [4:0] o_y,
  output logic       o_deny,
  output logic       o_busy,
  output logic [4:0] o_entry_idx,
  output logic       o_lib_full,
  output logic       o_reject
);

  localparam int              CW       = $clog2(LIB_DEPTH + 1);
  localparam logic [4:0]      IDX_LAST = 5'(LIB_DEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(LIB_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_FLUSH,
    S_COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    x_q, x_d;
  logic [4:0]    y_q, y_d;
  logic [CW-1:0] count_q, count_d;
  logic          start_q, start_d;
  logic          valid_q, valid_d;
  logic [4:0]    ox_q, ox_d;
  logic [4:0]    oy_q, oy_d;
  logic          deny_q, deny_d;
  logic          busy_q, busy_d;
  logic [4:0]    idx_q, idx_d;
  logic          full_q, full_d;
  logic          reject_q, reject_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    count_d  = count_q;
    idx_d    = idx_q;
    full_d   = full_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    ox_d     = 5'd0;
    oy_d     = 5'd0;
    deny_d   = 1'b1;
    reject_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          if (full_q) begin
            reject_d = 1'b1;
          end else begin
            state_d = S_SCAN;
            start_d = 1'b1;
            x_d     = 5'd0;
            y_d     = 5'd0;
          end
        end
      end

      S_SCAN: begin
        if (i_pix_valid) begin
          if (i_pix >= THRESH) begin
            valid_d = 1'b1;
            ox_d    = x_q;
            oy_d    = y_q;
          end
          // The 5-bit column counter wraps 31 -> 0 on its own.
          x_d = x_q + 5'd1;
          if (x_q == 5'd31) begin
            y_d = y_q + 5'd1;
            if (y_q == 5'd31) begin
              state_d = S_FLUSH;
            end
          end
        end
      end

      // The flush cycle presents the last pixel's result. It only needs to
      // schedule the commit cycle, where deny drops.
      S_FLUSH: begin
        state_d = S_COMMIT;
        deny_d  = 1'b0;
      end

      S_COMMIT: begin
        state_d = S_IDLE;
        idx_d   = (idx_q == IDX_LAST) ? 5'd0 : idx_q + 5'd1;
        count_d = count_q + CW'(1);
        full_d  = ((count_q + CW'(1)) == CNT_FULL);
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A clear overrides any commit in the same cycle. The slot pointer is left
    // alone because the store's own pointer does not reset.
    if (i_lib_clear) begin
      count_d = '0;
      full_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      x_q      <= 5'd0;
      y_q      <= 5'd0;
      count_q  <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      ox_q     <= 5'd0;
      oy_q     <= 5'd0;
      deny_q   <= 1'b1;
      busy_q   <= 1'b0;
      idx_q    <= 5'd0;
      full_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      count_q  <= count_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      deny_q   <= deny_d;
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      full_q   <= full_d;
      reject_q <= reject_d;
    end
  end

  assign o_start     = start_q;
  assign o_valid     = valid_q;
  assign o_x         = ox_q;
  assign o_y         = oy_q;
  assign o_deny      = deny_q;
  assign o_busy      = busy_q;
  assign o_entry_idx = idx_q;
  assign o_lib_full  = full_q;
  assign o_reject    = reject_q;

endmodule

// File: tb/tb_library_point_extract.sv
// -----------------------------------------------------------------------------
// tb_library_point_extract
//
// Directed testbench for library_point_extract. Inputs change 1 ns after each
// rising edge. Outputs are sampled at the same point, so each sample shows the
// result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_library_point_extract;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_frame_start = 1'b0;
  logic       i_pix_valid = 1'b0;
  logic [7:0] i_pix = 8'd0;
  logic       i_lib_clear = 1'b0;
  logic       o_start, o_valid, o_deny, o_busy, o_lib_full, o_reject;
  logic [4:0] o_x, o_y, o_entry_idx;

  library_point_extract dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_frame_start(i_frame_start),
    .i_pix_valid  (i_pix_valid),
    .i_pix        (i_pix),
    .i_lib_clear  (i_lib_clear),
    .o_start      (o_start),
    .o_valid      (o_valid),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_deny       (o_deny),
    .o_busy       (o_busy),
    .o_entry_idx  (o_entry_idx),
    .o_lib_full   (o_lib_full),
    .o_reject     (o_reject)
  );

  always #5 i_clk = ~i_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] img [0:1023];
  logic [4:0] exp_idx   = 5'd0;
  int         exp_count = 0;
  int         n_points  = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 8'd0;
  endtask

  // Runs one accepted frame from the current image. Optionally inserts random
  // valid gaps, or drives stray inputs that must be ignored: a frame start in
  // SCAN, and pixels during FLUSH/COMMIT.
  task automatic run_frame(input bit gaps, input bit spurious, input string tag);
    logic       ev;
    logic [4:0] ex, ey;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    n_checks++;
    if ({o_start, o_busy, o_deny, o_valid} !== 4'b1110) begin
      n_fail++;
      $display("FAIL %s start_cycle: start/busy/deny/valid=%b expected 1110", tag,
               {o_start, o_busy, o_deny, o_valid});
    end
    for (int i = 0; i < 1024; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_pix_valid = 1'b0;
        i_pix       = 8'hff;
        step();
        n_checks++;
        if ({o_valid, o_start} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s gap_%0d: valid/start=%b expected 00", tag, i, {o_valid, o_start});
        end
      end
      if (spurious && i == 100) i_frame_start = 1'b1;
      i_pix_valid = 1'b1;
      i_pix       = img[i];
      step();
      i_frame_start = 1'b0;
      ev = (img[i] >= 8'd128);
      ex = ev ? 5'(i % 32) : 5'd0;
      ey = ev ? 5'(i / 32) : 5'd0;
      if (ev) n_points++;
      n_checks++;
      if ({o_valid, o_x, o_y} !== {ev, ex, ey}) begin
        n_fail++;
        $display("FAIL %s pix_%0d: valid/x/y=%0d/%0d/%0d expected %0d/%0d/%0d", tag, i,
                 o_valid, o_x, o_y, ev, ex, ey);
      end
      n_checks++;
      if ({o_start, o_deny, o_busy} !== 3'b011) begin
        n_fail++;
        $display("FAIL %s ctl_%0d: start/deny/busy=%b expected 011", tag, i,
                 {o_start, o_deny, o_busy});
      end
    end
    // Now in FLUSH (last pixel's result shown above). Next edge enters COMMIT.
    i_pix_valid = spurious;
    i_pix       = 8'hff;
    step();
    n_checks++;
    if ({o_deny, o_valid, o_busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s commit: deny/valid/busy=%b expected 001", tag, {o_deny, o_valid, o_busy});
    end
    step();
    i_pix_valid = 1'b0;
    exp_idx   = (exp_idx == 5'd25) ? 5'd0 : exp_idx + 5'd1;
    exp_count = exp_count + 1;
    n_checks++;
    if ({o_deny, o_valid, o_busy, o_start} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s idle: deny/valid/busy/start=%b expected 1000", tag,
               {o_deny, o_valid, o_busy, o_start});
    end
    n_checks++;
    if (o_entry_idx !== exp_idx || o_lib_full !== (exp_count >= 26)) begin
      n_fail++;
      $display("FAIL %s slot: idx=%0d full=%0d expected idx=%0d full=%0d", tag,
               o_entry_idx, o_lib_full, exp_idx, (exp_count >= 26));
    end
    $display("frame %s done: idx=%0d full=%0d points=%0d", tag, o_entry_idx, o_lib_full, n_points);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    exp_idx   = 5'd0;
    exp_count = 0;
    n_checks++;
    if ({o_start, o_valid, o_x, o_y, o_deny, o_busy, o_entry_idx, o_lib_full, o_reject} !==
        {1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: outputs start=%0d valid=%0d x=%0d y=%0d deny=%0d busy=%0d idx=%0d full=%0d rej=%0d expected deny=1 others 0",
               o_start, o_valid, o_x, o_y, o_deny, o_busy, o_entry_idx, o_lib_full, o_reject);
    end
  endtask

  task automatic test_zero_frame();
    clear_img();
    n_points = 0;
    run_frame(1'b0, 1'b0, "zero");
    n_checks++;
    if (o_entry_idx !== 5'd1) begin
      n_fail++;
      $display("FAIL zero_idx: idx=%0d expected 1", o_entry_idx);
    end
  endtask

  task automatic test_points();
    clear_img();
    img[3]    = 8'd128;
    img[1023] = 8'd200;
    n_points  = 0;
    run_frame(1'b0, 1'b0, "points");
  endtask

  task automatic test_gaps();
    clear_img();
    img[7*32 + 10] = 8'd127;
    img[7*32 + 11] = 8'd255;
    run_frame(1'b1, 1'b0, "gaps127");
    img[7*32 + 10] = 8'd128;
    run_frame(1'b1, 1'b0, "gaps128");
  endtask

  task automatic test_wrap_full();
    test_reset();
    clear_img();
    for (int f = 0; f < 26; f++) run_frame(1'b0, 1'b0, "fill");
    n_checks++;
    if ({o_entry_idx, o_lib_full} !== {5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_full: idx=%0d full=%0d expected idx=0 full=1", o_entry_idx, o_lib_full);
    end
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    n_checks++;
    if ({o_reject, o_start, o_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reject_27: reject/start/busy=%b expected 100", {o_reject, o_start, o_busy});
    end
    step();
    n_checks++;
    if (o_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_pulse: reject=%0d expected 0", o_reject);
    end
    i_frame_start = 1'b1;
    i_lib_clear   = 1'b1;
    step();
    i_frame_start = 1'b0;
    i_lib_clear   = 1'b0;
    exp_count = 0;
    n_checks++;
    if ({o_reject, o_start, o_lib_full, o_busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL clear_and_start: reject/start/full/busy=%b expected 1000",
               {o_reject, o_start, o_lib_full, o_busy});
    end
    run_frame(1'b0, 1'b0, "after_clear");
  endtask

  task automatic test_reset_mid();
    clear_img();
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      i_pix_valid = 1'b1;
      i_pix       = 8'd0;
      step();
    end
    i_rst = 1'b1;
    i_pix = 8'hff;
    step();
    i_rst       = 1'b0;
    i_pix_valid = 1'b0;
    exp_idx   = 5'd0;
    exp_count = 0;
    n_checks++;
    if ({o_start, o_valid, o_x, o_y, o_deny, o_busy, o_entry_idx, o_lib_full, o_reject} !==
        {1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: start=%0d valid=%0d x=%0d y=%0d deny=%0d busy=%0d idx=%0d full=%0d rej=%0d expected deny=1 others 0",
               o_start, o_valid, o_x, o_y, o_deny, o_busy, o_entry_idx, o_lib_full, o_reject);
    end
    img[0]   = 8'd200;
    img[545] = 8'd130;
    run_frame(1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_spurious();
    i_pix_valid = 1'b1;
    i_pix       = 8'hff;
    step();
    step();
    i_pix_valid = 1'b0;
    n_checks++;
    if ({o_valid, o_busy, o_x, o_y} !== 12'd0) begin
      n_fail++;
      $display("FAIL idle_pix: valid=%0d busy=%0d x=%0d y=%0d expected all 0",
               o_valid, o_busy, o_x, o_y);
    end
    clear_img();
    img[0]   = 8'd255;
    img[101] = 8'd128;
    run_frame(1'b0, 1'b1, "spurious1");
    clear_img();
    img[0]  = 8'd129;
    img[33] = 8'd129;
    run_frame(1'b0, 1'b0, "spurious2");
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_points();
    test_gaps();
    test_wrap_full();
    test_reset_mid();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
